// File: rtl/ysyx_25030081_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch
// (master 0) and load/store (master 1). Only one transaction is in flight at
// a time; the arbiter re-arbitrates in IDLE between transactions.
module ysyx_25030081_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    // instruction fetch master (read only)
    input  logic                      if_req_valid,
    output logic                      if_req_ready,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_resp_valid,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    // load/store master
    input  logic                      ls_req_valid,
    output logic                      ls_req_ready,
    input  logic [ADDR_WIDTH-1:0]     ls_addr,
    input  logic                      ls_wen,
    input  logic [DATA_WIDTH-1:0]     ls_wdata,
    input  logic [DATA_WIDTH/8-1:0]   ls_wmask,
    output logic                      ls_resp_valid,
    output logic [DATA_WIDTH-1:0]     ls_rdata,
    // memory port
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic                      mem_wen,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wmask,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_LS,
        WAIT_IF,
        WAIT_LS
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_ls;
    logic   last_ls_next;

    // State register and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_ls <= 1'b0;
        end else begin
            state   <= state_next;
            last_ls <= last_ls_next;
        end
    end

    // Next-state, grant bookkeeping and combinational forwarding of the granted master
    always_comb begin
        state_next    = state;
        last_ls_next  = last_ls;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        if_rdata      = '0;
        ls_rdata      = '0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wdata     = '0;
        mem_wmask     = '0;

        // Outputs are held quiet while reset is asserted, even before the
        // state register has been cleared on the next edge.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (if_req_valid && ls_req_valid) begin
                        if (!last_ls) begin
                            state_next   = REQ_LS;
                            last_ls_next = 1'b1;
                        end else begin
                            state_next   = REQ_IF;
                            last_ls_next = 1'b0;
                        end
                    end else if (if_req_valid) begin
                        state_next   = REQ_IF;
                        last_ls_next = 1'b0;
                    end else if (ls_req_valid) begin
                        state_next   = REQ_LS;
                        last_ls_next = 1'b1;
                    end
                end
                REQ_IF: begin
                    mem_req_valid = 1'b1;
                    mem_addr      = if_addr;
                    if_req_ready  = mem_req_ready;
                    if (mem_req_ready) begin
                        state_next = WAIT_IF;
                    end
                end
                REQ_LS: begin
                    mem_req_valid = 1'b1;
                    mem_addr      = ls_addr;
                    mem_wen       = ls_wen;
                    mem_wdata     = ls_wdata;
                    mem_wmask     = ls_wmask;
                    ls_req_ready  = mem_req_ready;
                    if (mem_req_ready) begin
                        state_next = WAIT_LS;
                    end
                end
                WAIT_IF: begin
                    if (mem_resp_valid) begin
                        if_resp_valid = 1'b1;
                        if_rdata      = mem_rdata;
                        state_next    = IDLE;
                    end
                end
                WAIT_LS: begin
                    if (mem_resp_valid) begin
                        ls_resp_valid = 1'b1;
                        ls_rdata      = mem_rdata;
                        state_next    = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
